sp_ram_gen: RTL
===============

# sp_ram_gen

Parametrised single-port synchronous RAM for MachXO2-class EBR designs. It generalises the fixed 9-bit/8K single-port EBR wrapper to arbitrary data width and depth. Over that fixed wrapper it adds selectable write mode, an optional output pipeline register and a built-in post-reset memory-clear sequencer with a BUSY handshake. It sits directly under user logic wherever a single-port buffer is needed, and is the single-port building block for FIFOs and lookup tables.

## Interface
- DATA_WIDTH, 9: word width, 1..36.
- ADDR_WIDTH, 10: address width. Depth = 2**ADDR_WIDTH.
- REGMODE, "NOREG": "NOREG" gives 1-cycle read; "OUTREG" adds an output register (2-cycle read).
- WRITEMODE, "NORMAL": "NORMAL", "WRITETHROUGH" or "READBEFOREWRITE"; sets DO behaviour on a write cycle.
- CSDECODE, 3'b000: CS value that selects the block.
- CLEAR_ON_RESET, 1: when 1, the whole array is written with CLEAR_VALUE after RSTN release.
- CLEAR_VALUE, 0: DATA_WIDTH-bit fill word.
- CLK  in  1  clock; all state on rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- CE  in  1  clock enable for array access.
- OCE  in  1  output-register clock enable; used only when REGMODE is "OUTREG".
- WE  in  1  1 = write, 0 = read.
- CS  in  3  chip select, compared against CSDECODE.
- RST  in  1  synchronous reset of the output latch and output register only; array contents unaffected.
- AD  in  ADDR_WIDTH  address.
- DI  in  DATA_WIDTH  write data.
- PINJ  in  1  parity-error injection. Ignored unless SP_RAM_PARITY_EN is defined.
- DO  out  DATA_WIDTH  read data.
- BUSY  out  1  high while the clear sequencer owns the array.
- PERR  out  1  parity error, aligned with DO.

## Operation
- Access condition: acc = CE & (CS==CSDECODE) & ~BUSY. With acc low, the array is untouched and the output latch holds its value.
- Write (acc & WE): mem[AD] <= DI. The latch then depends on WRITEMODE:
  - NORMAL: latch holds.
  - WRITETHROUGH: latch <= DI.
  - READBEFOREWRITE: latch <= old mem[AD].
- Read (acc & ~WE): latch <= mem[AD].
- Output path:
  - NOREG: DO = latch.
  - OUTREG: outreg <= latch when OCE; DO = outreg.
- RST (synchronous) clears the latch, and outreg when present, to 0. RST has priority over any load in the same cycle.
- Clear sequencer states:
  - CLEAR: writes CLEAR_VALUE to address cnt, then cnt increments. After the write to address 2**ADDR_WIDTH-1, the sequencer moves to RUN. The counter is ADDR_WIDTH+1 bits so the terminal value does not wrap.
  - RUN: normal operation; the sequencer never leaves RUN except through RSTN.
  - With CLEAR_ON_RESET=0, the sequencer resets directly into RUN.
- BUSY = (state==CLEAR). User accesses issued while BUSY is high are dropped with no queuing.
- RSTN asserted at any time, including mid-clear:
  - state = CLEAR, or RUN when CLEAR_ON_RESET=0; cnt = 0.
  - Latch, outreg and DO = 0; PERR = 0.
  - BUSY = CLEAR_ON_RESET.
  - A clear interrupted by reset restarts from address 0.
- Out-of-range addresses cannot occur, because depth is a power of two.

## Timing
- Read latency from the acc edge to valid DO: 1 cycle in NOREG. In OUTREG it is 2 cycles, provided OCE is high on the second edge.
- Back-to-back accesses are sustained at one per cycle; there are no bubbles.
- Clear duration is exactly 2**ADDR_WIDTH cycles after the first rising edge with RSTN high. BUSY falls on the edge that performs the last clear write.
- The first user access is accepted on the edge following BUSY low.
- A read of address A in the cycle after a write to A returns the new data.

## Configuration
- SP_RAM_PARITY_EN defined:
  - The array is DATA_WIDTH+1 bits wide. The extra bit holds even parity of DI, inverted when PINJ=1 on the write.
  - Clear writes correct parity.
  - PERR is registered through the same latch and outreg path as DO, so it is cycle-aligned with DO. A WRITETHROUGH write cycle gives PERR=0.
- SP_RAM_PARITY_EN undefined: array is DATA_WIDTH bits, PINJ is ignored and PERR is tied to 0.

## Structure
- Package sp_ram_pkg holds:
  - the state enum {CLEAR, RUN};
  - WRITEMODE/REGMODE string constants;
  - the function even_parity(logic [35:0], width).
- Sub-module sp_ram_clear_seq contains the state register, address counter and BUSY generation. It drives the clear write-enable, address and data into the top-level array-port mux.

## Test plan
- Reset release with ADDR_WIDTH=4, CLEAR_VALUE=9'h1A5 -> BUSY high exactly 16 cycles; reads of addresses 0..15 all return 9'h1A5.
- NOREG: write 9'h0F3 to address 5, then read address 5 -> DO=9'h0F3 one cycle after the read edge. OUTREG with OCE=1 -> DO=9'h0F3 two cycles after the read edge.
- Each WRITEMODE: preload address 2 with 9'h011, then write 9'h122 to address 2 -> DO is 9'h011 (held) for NORMAL; 9'h122 for WRITETHROUGH; 9'h011 (old data) for READBEFOREWRITE.
- CS=3'b001 with CSDECODE=3'b000, write 9'h1FF to address 3 -> memory unchanged, DO holds. Synchronous RST during a read -> DO=0.
- RSTN pulsed low at clear count 7 -> DO=0 immediately; BUSY stays high; the clear restarts and lasts the full 16 cycles.
- With SP_RAM_PARITY_EN: write 9'h001 with PINJ=1, then read -> PERR=1 aligned with DO=9'h001. Write with PINJ=0 and read -> PERR=0.

Source files
------------

// File: rtl/sp_ram_pkg.sv
// sp_ram_pkg: shared state enum, mode names and parity helper for sp_ram_gen.
package sp_ram_pkg;

    typedef enum logic {CLEAR, RUN} state_e;

    localparam string RM_NOREG           = "NOREG";
    localparam string RM_OUTREG          = "OUTREG";
    localparam string WM_NORMAL          = "NORMAL";
    localparam string WM_WRITETHROUGH    = "WRITETHROUGH";
    localparam string WM_READBEFOREWRITE = "READBEFOREWRITE";

    function automatic logic even_parity(input logic [35:0] d, input int width);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 36; i++) begin
            if (i < width) p = p ^ d[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/sp_ram_clear_seq.sv
// sp_ram_clear_seq: post-reset array fill sequencer; owns the array port while busy_o is high.
module sp_ram_clear_seq import sp_ram_pkg::*; #(
    parameter int            ADDR_WIDTH     = 10,
    parameter int            MW             = 9,
    parameter int            CLEAR_ON_RESET = 1,
    parameter logic [MW-1:0] CLEAR_WORD     = '0
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    output logic                  busy_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [MW-1:0]         data_o
);

    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'((2 ** ADDR_WIDTH) - 1);

    state_e              state_q;
    logic [ADDR_WIDTH:0] cnt_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            cnt_q   <= '0;
        end else if (state_q == CLEAR) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) state_q <= RUN;
        end
    end

    assign busy_o = (state_q == CLEAR);
    assign we_o   = busy_o;
    assign addr_o = cnt_q[ADDR_WIDTH-1:0];
    assign data_o = CLEAR_WORD;

endmodule

// File: rtl/sp_ram_gen.sv
// sp_ram_gen: parametrised single-port synchronous RAM with write modes, optional output register and clear-on-reset.
// Define SP_RAM_PARITY_EN to store a parity bit per word and report PERR aligned with DO.
module sp_ram_gen import sp_ram_pkg::*; #(
    parameter int                    DATA_WIDTH     = 9,
    parameter int                    ADDR_WIDTH     = 10,
    parameter string                 REGMODE        = "NOREG",
    parameter string                 WRITEMODE      = "NORMAL",
    parameter logic [2:0]            CSDECODE       = 3'b000,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  CE,
    input  logic                  OCE,
    input  logic                  WE,
    input  logic [2:0]            CS,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] AD,
    input  logic [DATA_WIDTH-1:0] DI,
    input  logic                  PINJ,
    output logic [DATA_WIDTH-1:0] DO,
    output logic                  BUSY,
    output logic                  PERR
);

    localparam bit OREG   = (REGMODE == RM_OUTREG);
    localparam bit WM_WT  = (WRITEMODE == WM_WRITETHROUGH);
    localparam bit WM_RBW = (WRITEMODE == WM_READBEFOREWRITE);

`ifdef SP_RAM_PARITY_EN
    localparam int MW = DATA_WIDTH + 1;
    localparam logic [MW-1:0] CLEAR_WORD = {even_parity(36'(CLEAR_VALUE), DATA_WIDTH), CLEAR_VALUE};
`else
    localparam int MW = DATA_WIDTH;
    localparam logic [MW-1:0] CLEAR_WORD = CLEAR_VALUE;
`endif

    logic [MW-1:0]         mem [2 ** ADDR_WIDTH];
    logic                  cwe;
    logic [ADDR_WIDTH-1:0] caddr;
    logic [MW-1:0]         cdata;
    logic                  acc;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [MW-1:0]         wr_data;
    logic [MW-1:0]         user_word;
    logic [MW-1:0]         rd_word;
    logic                  rd_perr;
    logic [DATA_WIDTH:0]   lat_q, lat_d;
    logic [DATA_WIDTH:0]   out_q, out_d;

    sp_ram_clear_seq #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .MW            (MW),
        .CLEAR_ON_RESET(CLEAR_ON_RESET),
        .CLEAR_WORD    (CLEAR_WORD)
    ) u_clear (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .busy_o(BUSY),
        .we_o  (cwe),
        .addr_o(caddr),
        .data_o(cdata)
    );

`ifdef SP_RAM_PARITY_EN
    assign user_word = {even_parity(36'(DI), DATA_WIDTH) ^ PINJ, DI};
    assign rd_perr   = ^rd_word;
`else
    logic unused_pinj;
    assign unused_pinj = PINJ;
    assign user_word   = DI;
    assign rd_perr     = 1'b0;
`endif

    assign acc     = CE & (CS == CSDECODE) & ~BUSY;
    assign wr_en   = cwe | (acc & WE);
    assign wr_addr = cwe ? caddr : AD;
    assign wr_data = cwe ? cdata : user_word;
    assign rd_word = mem[AD];

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Latch carries {perr, data} so PERR stays cycle-aligned with DO through the output register.
    always_comb begin
        lat_d = RST    ? '0 :
                !acc   ? lat_q :
                !WE    ? {rd_perr, rd_word[DATA_WIDTH-1:0]} :
                WM_WT  ? {1'b0, DI} :
                WM_RBW ? {rd_perr, rd_word[DATA_WIDTH-1:0]} : lat_q;
        out_d = RST ? '0 : OCE ? lat_q : out_q;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            lat_q <= '0;
            out_q <= '0;
        end else begin
            lat_q <= lat_d;
            out_q <= out_d;
        end
    end

    assign {PERR, DO} = OREG ? out_q : lat_q;

endmodule
